// File: rtl/seq_det_prog.sv
// ---------------------------------------------------------------------------
// seq_det_prog
//
// Programmable serial pattern detector. One bit is accepted per cycle with
// in_valid high and matched against a runtime-loadable pattern of 1..PAT_W
// bits. The oldest bit of the window lines up with pat[len-1] and the newest
// with pat[0]. Matching can be overlapping or non-overlapping, selected per
// accepted bit. The detect pulse is registered (Moore-style), so det_o never
// follows seq_in combinationally.
//
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   seq_in     in   1      serial data bit
//   in_valid   in   1      seq_in is accepted only when high
//   overlap    in   1      1 = overlapping match, 0 = non-overlapping
//   pat_load   in   1      capture pat_value/pat_len; wins over in_valid
//   pat_value  in   PAT_W  new pattern, LSB-aligned
//   pat_len    in   LEN_W  new pattern length (clamped to PAT_W, 0 disables)
//   det_o      out  1      one-cycle detect pulse
//   det_count  out  CNT_W  saturating detection count
//
// Build option:
//   SEQ_DET_COUNT_EN  when defined, det_count counts detections. When
//                     undefined, the counter is removed and det_count is 0.
// ---------------------------------------------------------------------------
module seq_det_prog #(
    parameter int               PAT_W   = 8,
    parameter int               LEN_W   = 5,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'h05),
    parameter logic [LEN_W-1:0] RST_LEN = LEN_W'(3)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             seq_in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_value,
    input  logic [LEN_W-1:0] pat_len,
    output logic             det_o,
    output logic [CNT_W-1:0] det_count
);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] fill;

    logic [PAT_W-1:0] cand;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W:0]   fill_inc;
    logic [LEN_W-1:0] fill_next;
    logic [LEN_W-1:0] load_len;
    logic             match_now;

    // Candidate window and match decision for the bit being offered this
    // cycle. fill_inc is one bit wider so fill+1 cannot wrap. Only the low
    // len bits of window and pattern take part in the compare.
    always_comb begin
        cand     = {hist[PAT_W-2:0], seq_in};
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(len)) begin
                len_mask[i] = 1'b1;
            end
        end
        fill_inc  = {1'b0, fill} + 1'b1;
        match_now = (len != '0) &&
                    (fill_inc >= {1'b0, len}) &&
                    ((cand & len_mask) == (pat & len_mask));
        fill_next = (fill_inc >= {1'b0, len}) ? len : fill_inc[LEN_W-1:0];
        load_len  = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
    end

    // Detector state. A load restarts matching from an empty window and
    // swallows any bit offered in the same cycle. In non-overlapping mode a
    // match empties the window so the next match needs len fresh bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pat   <= RST_PAT;
            len   <= RST_LEN;
            hist  <= '0;
            fill  <= '0;
            det_o <= 1'b0;
        end else if (pat_load) begin
            pat   <= pat_value;
            len   <= load_len;
            hist  <= '0;
            fill  <= '0;
            det_o <= 1'b0;
        end else if (in_valid) begin
            hist  <= cand;
            det_o <= match_now;
            fill  <= (match_now && !overlap) ? '0 : fill_next;
        end else begin
            det_o <= 1'b0;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] count_q;

    // Counts on the same edge that raises det_o and sticks at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (!pat_load && in_valid && match_now && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign det_count = count_q;
`else
    assign det_count = '0;
`endif

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Programmable serial pattern detector, the parametrised generalisation of the fixed "101" Moore detector. It accepts one bit per valid cycle and matches it against a runtime-loadable pattern of 1..PAT_W bits. Overlapping or non-overlapping matching is selected at runtime. It sits on a serial input stream and drives a registered one-cycle detect pulse plus an optional detection counter to downstream control logic.

## Interface
- PAT_W, 8: maximum pattern length in bits (2..16).
- LEN_W, 5: width of the length field; must hold values 0..PAT_W.
- CNT_W, 8: detection counter width.
- RST_PAT, 8'h05: pattern after reset, LSB-aligned.
- RST_LEN, 3: pattern length after reset (together with RST_PAT gives "101").

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- seq_in  in  1  serial data bit.
- in_valid  in  1  seq_in is sampled only when high.
- overlap  in  1  1 = overlapping match, 0 = non-overlapping.
- pat_load  in  1  capture pat_value/pat_len this cycle.
- pat_value  in  PAT_W  new pattern, LSB-aligned.
- pat_len  in  LEN_W  new pattern length.
- det_o  out  1  registered detect pulse.
- det_count  out  CNT_W  saturating count of detections.

## Operation
- Internal state:
  - hist[PAT_W-1:0]: shift register, newest bit at [0].
  - fill: number of valid history bits, 0..len.
  - pat, len: active pattern and length registers.
- Bit order: the oldest bit of the window is compared to pat[len-1], the newest to pat[0].
- On in_valid, form cand = {hist[PAT_W-2:0], seq_in}. A match occurs when fill+1 >= len, len != 0, and cand[len-1:0] == pat[len-1:0].
- Every accepted bit (match or not):
  - hist <= cand.
  - fill <= min(fill+1, len).
- On a match:
  - If overlap=1: fill stays at len, so the match suffix can be reused by the next match.
  - If overlap=0: fill <= 0, so the next match needs len fresh bits.
- det_o <= match in the same edge. det_o is 0 on any cycle with in_valid=0.
- pat_load:
  - Loads pat <= pat_value and len <= min(pat_len, PAT_W).
  - Clears hist, fill and det_o.
  - Has priority over in_valid in the same cycle; that bit is discarded.
  - Does not clear det_count.
- len = 0: the detector is disabled. det_o stays 0 and bits are still shifted.
- overlap may change on any cycle and applies to the next accepted bit.

## Timing
- Reset (reset low, asynchronous) sets:
  - pat=RST_PAT, len=RST_LEN, hist=0, fill=0.
  - det_o=0, det_count=0.
- Release of reset is synchronised by the integrator. The first bit can be accepted on the first rising edge with reset high.
- Latency: det_o is high for exactly the one cycle after the edge that accepted the final pattern bit (Moore-style registered output). The output never depends combinationally on seq_in.
- Back-to-back matches in overlap mode give det_o high on consecutive valid cycles.
- in_valid gaps freeze hist and fill; a pattern may be split across gaps.
- Reset asserted mid-pattern discards the partial match. No det_o is produced for it.
- det_count increments on the same edge that sets det_o and saturates at 2^CNT_W-1 (no wrap).

## Configuration
- SEQ_DET_COUNT_EN defined: det_count is implemented as described.
- SEQ_DET_COUNT_EN undefined: the counter logic is removed, the det_count port remains and is tied to 0. All other behaviour is identical.

## Test plan
- Reset defaults, overlap=1, stream 0,1,0,1,0,1,1 -> det_o pulses after the 4th and 6th bits; det_count=2 (with SEQ_DET_COUNT_EN).
- Same stream with overlap=0 -> det_o pulses only after the 4th bit; det_count=1.
- Load pat_value=8'hB2, pat_len=8, overlap=0; send 10110010 twice with in_valid dropped for 3 cycles mid-second-pattern -> exactly 2 pulses, each one cycle after the final bit.
- Load pat_len=0, send 16 alternating bits -> det_o never rises. Load pat_len=12 with PAT_W=8 -> length clamps to 8.
- Reset low mid-pattern (after "10" of "101"), release, send "1" -> no pulse. Then "01" -> pulse; det_count reads 1.
- CNT_W=2, overlap=1, pattern "11", stream of 8 ones -> 7 pulses; det_count holds 3 from the 3rd detection onward. Undefined macro -> det_count stays 0 throughout.
